// File: rtl/num_display_seq.sv
// -----------------------------------------------------------------------------
// num_display_seq
//
// Turns a signed calculator result into a right-aligned stream of display
// symbols for the 7-segment/LCD driver. The value is latched on start. A
// sequential double-dabble then converts its magnitude to BCD. Exactly
// DISP_WIDTH symbols follow, leftmost position first, over a valid/ready
// handshake.
//
// Symbol codes: 0-9 digit, 0xA minus sign, 0xE error (overflow), 0xF blank.
//
// Optional feature (compile-time macro NUMDISP_ZERO_PAD_EN):
//   When the macro is defined, unused positions left of the number show '0'
//   instead of blank. For a negative value the minus sign is placed at the
//   leftmost position. Overflow output is the same in both builds.
//
// Parameters
//   WIDTH       input value width (two's complement); the digit counter below
//               is built for 22 bits, so keep this at 22
//   DISP_WIDTH  symbols per conversion, 7..8 (sign + 6 digits, 3-bit sym_pos)
//
// Ports
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   start      in   request conversion of value; accepted only when busy=0
//   value      in   [WIDTH-1:0] signed result to display
//   busy       out  high from accepting start through the last handshake
//   sym_valid  out  sym/sym_pos hold a valid symbol
//   sym_ready  in   consumer accepts the symbol on sym_valid & sym_ready
//   sym        out  [3:0] symbol code
//   sym_pos    out  [2:0] position of sym, DISP_WIDTH-1 (leftmost) down to 0
//   length     out  [2:0] digit count 1..6, captured at start
//   overflow   out  |value| > 999999, captured at start
//   done       out  one-cycle pulse after the final symbol handshake
// -----------------------------------------------------------------------------

// Decimal digit count of a 22-bit two's complement value, saturating at 6.
module numlength (
  input  logic [21:0] value,
  output logic [2:0]  length
);

  logic [21:0] mag;

  // -2^21 negates to 2^21, which is still correct when read as unsigned.
  assign mag = value[21] ? (~value + 22'd1) : value;

  always_comb begin
    length = 3'd6;
    if (mag < 22'd10)          length = 3'd1;
    else if (mag < 22'd100)    length = 3'd2;
    else if (mag < 22'd1000)   length = 3'd3;
    else if (mag < 22'd10000)  length = 3'd4;
    else if (mag < 22'd100000) length = 3'd5;
  end

endmodule

module num_display_seq #(
  parameter int WIDTH      = 22,
  parameter int DISP_WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] value,
  output logic             busy,
  output logic             sym_valid,
  input  logic             sym_ready,
  output logic [3:0]       sym,
  output logic [2:0]       sym_pos,
  output logic [2:0]       length,
  output logic             overflow,
  output logic             done
);

  localparam int         BCD_DIGITS = 7;
  localparam int         BCD_W      = 4 * BCD_DIGITS;
  localparam logic [2:0] POS_MAX    = 3'(DISP_WIDTH - 1);
  localparam logic [4:0] LAST_STEP  = 5'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONVERT,
    S_EMIT
  } state_t;

  state_t             state_reg,     state_next;
  logic [WIDTH-1:0]   shift_reg,     shift_next;
  logic [BCD_W-1:0]   bcd_reg,       bcd_next;
  logic [4:0]         cnt_reg,       cnt_next;
  logic               neg_reg,       neg_next;
  logic               busy_reg,      busy_next;
  logic               sym_valid_reg, sym_valid_next;
  logic               done_reg,      done_next;
  logic               overflow_reg,  overflow_next;
  logic [2:0]         length_reg,    length_next;
  logic [3:0]         sym_reg,       sym_next;
  logic [2:0]         sym_pos_reg,   sym_pos_next;

  logic [WIDTH-1:0]   abs_value;
  logic [2:0]         num_len;
  logic [BCD_W-1:0]   bcd_adj;
  logic [BCD_W-1:0]   bcd_step;
  logic [WIDTH-1:0]   shift_step;

  // Magnitude of the incoming value. -2^21 maps to 2^21 as unsigned.
  assign abs_value = value[WIDTH-1] ? (~value + 1'b1) : value;

  numlength u_numlength (
    .value  (value),
    .length (num_len)
  );

  // Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift.
  generate
    for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_dabble
      assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ?
                                  (bcd_reg[4*gi +: 4] + 4'd3) :
                                  bcd_reg[4*gi +: 4];
    end
  endgenerate

  // Shift the corrected BCD left by one and bring in the next binary MSB.
  // Seven nibbles hold 2^21 = 2097152, so the bit shifted out is always 0.
  assign bcd_step   = BCD_W'({bcd_adj, shift_reg[WIDTH-1]});
  assign shift_step = {shift_reg[WIDTH-2:0], 1'b0};

  // Symbol shown at display position pos for a finished conversion.
  function automatic logic [3:0] pick_sym(
    input logic [2:0]       pos,
    input logic [BCD_W-1:0] bcd,
    input logic [2:0]       len,
    input logic             neg,
    input logic             ovf
  );
    logic [3:0] s;
    s = 4'hF;
    if (ovf) begin
      s = (pos == 3'd0) ? 4'hE : 4'hF;
    end else if (pos < len) begin
      for (int i = 0; i < BCD_DIGITS; i++) begin
        if (pos == 3'(i)) s = bcd[4*i +: 4];
      end
    end else begin
`ifdef NUMDISP_ZERO_PAD_EN
      s = (neg && (pos == POS_MAX)) ? 4'hA : 4'h0;
`else
      s = (neg && (pos == len)) ? 4'hA : 4'hF;
`endif
    end
    return s;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= S_IDLE;
      shift_reg     <= '0;
      bcd_reg       <= '0;
      cnt_reg       <= '0;
      neg_reg       <= 1'b0;
      busy_reg      <= 1'b0;
      sym_valid_reg <= 1'b0;
      done_reg      <= 1'b0;
      overflow_reg  <= 1'b0;
      length_reg    <= 3'd1;
      sym_reg       <= 4'hF;
      sym_pos_reg   <= POS_MAX;
    end else begin
      state_reg     <= state_next;
      shift_reg     <= shift_next;
      bcd_reg       <= bcd_next;
      cnt_reg       <= cnt_next;
      neg_reg       <= neg_next;
      busy_reg      <= busy_next;
      sym_valid_reg <= sym_valid_next;
      done_reg      <= done_next;
      overflow_reg  <= overflow_next;
      length_reg    <= length_next;
      sym_reg       <= sym_next;
      sym_pos_reg   <= sym_pos_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    shift_next     = shift_reg;
    bcd_next       = bcd_reg;
    cnt_next       = cnt_reg;
    neg_next       = neg_reg;
    busy_next      = busy_reg;
    sym_valid_next = sym_valid_reg;
    done_next      = 1'b0;
    overflow_next  = overflow_reg;
    length_next    = length_reg;
    sym_next       = sym_reg;
    sym_pos_next   = sym_pos_reg;

    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next    = S_CONVERT;
          shift_next    = abs_value;
          bcd_next      = '0;
          cnt_next      = '0;
          neg_next      = value[WIDTH-1];
          length_next   = num_len;
          overflow_next = (abs_value > WIDTH'(999999));
          busy_next     = 1'b1;
        end
      end

      S_CONVERT: begin
        shift_next = shift_step;
        bcd_next   = bcd_step;
        cnt_next   = cnt_reg + 5'd1;
        // The last step and the first symbol are produced on the same edge.
        // The leftmost symbol is therefore looked up from the freshly
        // stepped BCD.
        if (cnt_reg == LAST_STEP) begin
          state_next     = S_EMIT;
          sym_valid_next = 1'b1;
          sym_pos_next   = POS_MAX;
          sym_next       = pick_sym(POS_MAX, bcd_step, length_reg,
                                    neg_reg, overflow_reg);
        end
      end

      S_EMIT: begin
        if (sym_valid_reg && sym_ready) begin
          if (sym_pos_reg == 3'd0) begin
            state_next     = S_IDLE;
            sym_valid_next = 1'b0;
            busy_next      = 1'b0;
            done_next      = 1'b1;
            sym_next       = 4'hF;
            sym_pos_next   = POS_MAX;
          end else begin
            sym_pos_next = sym_pos_reg - 3'd1;
            sym_next     = pick_sym(sym_pos_reg - 3'd1, bcd_reg, length_reg,
                                    neg_reg, overflow_reg);
          end
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign busy      = busy_reg;
  assign sym_valid = sym_valid_reg;
  assign sym       = sym_reg;
  assign sym_pos   = sym_pos_reg;
  assign length    = length_reg;
  assign overflow  = overflow_reg;
  assign done      = done_reg;

endmodule

// File: tb/tb_num_display_seq.sv
// -----------------------------------------------------------------------------
// tb_num_display_seq
//
// Scoreboard bench for num_display_seq. Each accepted start pushes the
// expected symbol stream into a queue. The stream comes from an integer
// decimal model. A monitor pops and compares an entry on every handshake.
// Inputs change 1 ns after the rising edge. Outputs are sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_num_display_seq;

  localparam int WIDTH = 22;
  localparam int DW    = 8;

  logic             clk;
  logic             reset_n;
  logic             start;
  logic [WIDTH-1:0] value;
  logic             busy;
  logic             sym_valid;
  logic             sym_ready;
  logic [3:0]       sym;
  logic [2:0]       sym_pos;
  logic [2:0]       length;
  logic             overflow;
  logic             done;

  int tests_run;
  int tests_failed;

  logic [6:0] exp_q[$];   // {pos[2:0], sym[3:0]}
  int         exp_len;
  bit         exp_ovf;

  logic       stall_q;
  logic [3:0] held_sym;
  logic [2:0] held_pos;

  num_display_seq #(
    .WIDTH      (WIDTH),
    .DISP_WIDTH (DW)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .value     (value),
    .busy      (busy),
    .sym_valid (sym_valid),
    .sym_ready (sym_ready),
    .sym       (sym),
    .sym_pos   (sym_pos),
    .length    (length),
    .overflow  (overflow),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int dec_digit(input int a, input int p);
    int t;
    t = a;
    for (int k = 0; k < p; k++) t = t / 10;
    return t % 10;
  endfunction

  // Expected stream for value v, built from plain integer arithmetic.
  task automatic push_expected(input int v);
    int         a;
    int         len;
    int         t;
    bit         ng;
    bit         ovf;
    logic [3:0] s;
    ng  = (v < 0);
    a   = ng ? -v : v;
    ovf = (a > 999999);
    len = 1;
    t   = a;
    while (t >= 10 && len < 6) begin
      t = t / 10;
      len++;
    end
    exp_len = len;
    exp_ovf = ovf;
    for (int p = DW - 1; p >= 0; p--) begin
      if (ovf) s = (p == 0) ? 4'hE : 4'hF;
      else if (p < len) s = 4'(dec_digit(a, p));
`ifdef NUMDISP_ZERO_PAD_EN
      else s = (ng && p == DW - 1) ? 4'hA : 4'h0;
`else
      else s = (ng && p == len) ? 4'hA : 4'hF;
`endif
      exp_q.push_back({3'(p), s});
    end
  endtask

  // Monitor: compare each handshake with the scoreboard and check that
  // sym and sym_pos hold steady while the consumer stalls.
  always @(negedge clk) begin
    logic [6:0] e;
    if (!reset_n) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q && sym_valid) begin
        check_val("stall_sym", 32'(sym), 32'(held_sym));
        check_val("stall_pos", 32'(sym_pos), 32'(held_pos));
      end
      if (sym_valid && sym_ready) begin
        if (exp_q.size() == 0) begin
          check_val("unexpected_sym", 32'(sym_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check_val("sym_pos", 32'(sym_pos), 32'(e[6:4]));
          check_val("sym", 32'(sym), 32'(e[3:0]));
        end
      end
      stall_q  = sym_valid && !sym_ready;
      held_sym = sym;
      held_pos = sym_pos;
    end
  end

  // Start one conversion and run it to done. ready_mode 0 keeps sym_ready
  // high and checks exact timing. ready_mode 1 toggles ready 1,0,0,1 and
  // fires a second start while busy.
  task automatic run_case(input int v, input int ready_mode);
    int n;
    bit pat[4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    value     = WIDTH'(v);
    start     = 1'b1;
    sym_ready = 1'b1;
    push_expected(v);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      #1;
      start = (ready_mode == 1 && n == 5);
      if (ready_mode == 1 && n == 5) value = WIDTH'(123);
      sym_ready = (ready_mode == 0) ? 1'b1 : pat[n % 4];
      @(negedge clk);
      if (n == 1) begin
        check_val("busy_after_start", 32'(busy), 32'd1);
        check_val("valid_after_start", 32'(sym_valid), 32'd0);
      end
      if (ready_mode == 0 && n == 22)
        check_val("valid_before_22", 32'(sym_valid), 32'd0);
      if (ready_mode == 0 && n == 23)
        check_val("valid_at_22", 32'(sym_valid), 32'd1);
    end while (!done && n < 400);
    check_val("done_seen", 32'(done), 32'd1);
    if (ready_mode == 0)
      check_val("latency", 32'(n), 32'(22 + DW + 1));
    check_val("busy_at_done", 32'(busy), 32'd0);
    check_val("valid_at_done", 32'(sym_valid), 32'd0);
    check_val("length", 32'(length), 32'(exp_len));
    check_val("overflow", 32'(overflow), 32'(exp_ovf));
    check_val("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] value=%0d length=%0d overflow=%0d cycles=%0d",
             v, length, overflow, n);
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, "_busy"}, 32'(busy), 32'd0);
    check_val({tag, "_valid"}, 32'(sym_valid), 32'd0);
    check_val({tag, "_done"}, 32'(done), 32'd0);
    check_val({tag, "_ovf"}, 32'(overflow), 32'd0);
    check_val({tag, "_sym"}, 32'(sym), 32'hF);
    check_val({tag, "_pos"}, 32'(sym_pos), 32'(DW - 1));
    check_val({tag, "_len"}, 32'(length), 32'd1);
  endtask

  // Start a conversion, then pull reset after 'cycles' edges.
  task automatic reset_mid(input int v, input int cycles, input bit ready_low,
                           input bit expect_valid, input string tag);
    @(posedge clk);
    #1;
    value     = WIDTH'(v);
    start     = 1'b1;
    sym_ready = !ready_low;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    check_val({tag, "_pre_valid"}, 32'(sym_valid), 32'(expect_valid));
    reset_n = 1'b0;
    #1;
    check_reset_state(tag);
    exp_q.delete();
    @(posedge clk);
    #1;
    reset_n   = 1'b1;
    sym_ready = 1'b1;
    $display("[TB] reset during %s", tag);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    stall_q      = 1'b0;
    reset_n      = 1'b0;
    start        = 1'b0;
    value        = '0;
    sym_ready    = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_state("reset");
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    run_case(0, 0);
    run_case(-1234, 0);
    run_case(999999, 0);
    run_case(-999999, 0);
    run_case(1000000, 0);
    run_case(-2097152, 0);
    run_case(2097151, 0);
    run_case(-42, 1);
    run_case(5, 0);

    reset_mid(12345, 10, 1'b0, 1'b0, "convert");
    reset_mid(-5678, 30, 1'b1, 1'b1, "emit");
    run_case(7, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
